// File: rtl/regfile_writer.sv
// Writeback stage: MEM/WB pipeline register, writeback source select and load extension,
// plus a clear-sweep FSM that zeroes x1..x(NREG-1) through the single regfile write port.
module regfile_writer #(
    parameter int NREG = 32,
    parameter int AW   = 5
) (
    input  logic          i_clk,
    input  logic          rst_n,
    input  logic          i_valid,
    input  logic          i_rd_wren,
    input  logic [AW-1:0] i_rd_addr,
    input  logic [1:0]    i_wb_sel,
    input  logic [2:0]    i_funct3,
    input  logic [31:0]   i_alu_data,
    input  logic [31:0]   i_mem_rdata,
    input  logic [31:0]   i_pc,
    input  logic          i_clear_req,
    output logic          o_busy,
    output logic          wren,
    output logic [AW-1:0] rd_addr,
    output logic [31:0]   rd_data,
    output logic          o_fwd_valid,
    output logic [AW-1:0] o_fwd_addr,
    output logic [31:0]   o_fwd_data,
    output logic          o_clear_done
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SWEEP = 2'd1,
        DONE  = 2'd2
    } state_t;

    localparam logic [AW-1:0] LAST_REG = AW'(NREG - 1);

    state_t        state;
    logic [AW-1:0] counter;

    logic          reg_valid;
    logic          reg_rd_wren;
    logic [AW-1:0] reg_rd_addr;
    logic [1:0]    reg_wb_sel;
    logic [2:0]    reg_funct3;
    logic [31:0]   reg_alu_data;
    logic [31:0]   reg_mem_rdata;
    logic [31:0]   reg_pc;

    logic [7:0]    load_byte;
    logic [15:0]   load_half;
    logic [31:0]   load_data;
    logic [31:0]   wb_data;

    assign o_busy = (state != IDLE) | i_clear_req;

    // The pipeline register only captures when the stage is not stalled; a stalled
    // cycle leaves valid low so the held instruction is taken once the stall lifts.
    always_ff @(posedge i_clk or negedge rst_n) begin
        if (!rst_n) begin
            state         <= IDLE;
            counter       <= AW'(1);
            o_clear_done  <= 1'b0;
            reg_valid     <= 1'b0;
            reg_rd_wren   <= 1'b0;
            reg_rd_addr   <= '0;
            reg_wb_sel    <= 2'b00;
            reg_funct3    <= 3'b000;
            reg_alu_data  <= 32'd0;
            reg_mem_rdata <= 32'd0;
            reg_pc        <= 32'd0;
        end else begin
            if (i_valid && !o_busy) begin
                reg_valid     <= 1'b1;
                reg_rd_wren   <= i_rd_wren;
                reg_rd_addr   <= i_rd_addr;
                reg_wb_sel    <= i_wb_sel;
                reg_funct3    <= i_funct3;
                reg_alu_data  <= i_alu_data;
                reg_mem_rdata <= i_mem_rdata;
                reg_pc        <= i_pc;
            end else begin
                reg_valid <= 1'b0;
            end

            o_clear_done <= 1'b0;
            case (state)
                IDLE: begin
                    if (i_clear_req) begin
                        state   <= SWEEP;
                        counter <= AW'(1);
                    end
                end
                SWEEP: begin
                    if (counter == LAST_REG) begin
                        state        <= DONE;
                        o_clear_done <= 1'b1;
                    end else begin
                        counter <= counter + AW'(1);
                    end
                end
                DONE: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    always_comb begin
        load_byte = 8'd0;
        case (reg_alu_data[1:0])
            2'd0: load_byte = reg_mem_rdata[7:0];
            2'd1: load_byte = reg_mem_rdata[15:8];
            2'd2: load_byte = reg_mem_rdata[23:16];
            2'd3: load_byte = reg_mem_rdata[31:24];
            default: load_byte = 8'd0;
        endcase
        load_half = reg_alu_data[1] ? reg_mem_rdata[31:16] : reg_mem_rdata[15:0];

        load_data = reg_mem_rdata;
        case (reg_funct3)
            3'b000:  load_data = {{24{load_byte[7]}}, load_byte};
            3'b100:  load_data = {24'd0, load_byte};
            3'b001:  load_data = {{16{load_half[15]}}, load_half};
            3'b101:  load_data = {16'd0, load_half};
            default: load_data = reg_mem_rdata;
        endcase

        wb_data = reg_alu_data;
        case (reg_wb_sel)
            2'b01:   wb_data = load_data;
            2'b10:   wb_data = reg_pc + 32'd4;
            default: wb_data = reg_alu_data;
        endcase
    end

    // The sweep owns the write port; otherwise the WB register drives it, never writing x0.
    always_comb begin
        wren    = 1'b0;
        rd_addr = reg_rd_addr;
        rd_data = wb_data;
        case (state)
            IDLE: begin
                wren = reg_valid & reg_rd_wren & (reg_rd_addr != '0);
            end
            SWEEP: begin
                wren    = 1'b1;
                rd_addr = counter;
                rd_data = 32'd0;
            end
            default: begin
                wren = 1'b0;
            end
        endcase
    end

    assign o_fwd_valid = wren;
    assign o_fwd_addr  = rd_addr;
    assign o_fwd_data  = rd_data;

endmodule

// File: doc/regfile_writer.md
Name: regfile_writer

Overview:
Writeback stage that drives the register file's single write port (wren, rd_addr, rd_data). It holds the MEM/WB pipeline register, selects the writeback source, and sign/zero-extends load data. It also runs a clear-sweep FSM that writes zero to x1..x(NREG-1) on request. The committed write is mirrored on a forwarding port for the hazard unit.

Parameters:
NREG, 32, number of architectural registers; the sweep ends at NREG-1
AW, 5, register address width; must satisfy 2^AW >= NREG

Ports:
i_clk  in  1  clock, rising edge
rst_n  in  1  asynchronous active-low reset
i_valid  in  1  MEM stage holds a valid instruction
i_rd_wren  in  1  instruction writes rd
i_rd_addr  in  AW  destination register
i_wb_sel  in  2  source select: 00 = ALU, 01 = load, 10 = pc+4, 11 = ALU
i_funct3  in  3  load type
i_alu_data  in  32  ALU result; bits [1:0] give the load byte offset
i_mem_rdata  in  32  raw aligned load word
i_pc  in  32  instruction PC
i_clear_req  in  1  request a register-file clear sweep
o_busy  out  1  upstream stall; MEM stage must hold its inputs
wren  out  1  regfile write enable
rd_addr  out  AW  regfile write address
rd_data  out  32  regfile write data
o_fwd_valid  out  1  equals wren
o_fwd_addr  out  AW  equals rd_addr
o_fwd_data  out  32  equals rd_data
o_clear_done  out  1  one-cycle pulse when the sweep completes

Behaviour:
- Reset (async, rst_n = 0):
  - state = IDLE; WB register valid = 0; sweep counter = 1.
  - All outputs 0, except o_busy, which follows i_clear_req combinationally (the state term is 0).
- MEM/WB register:
  - Captures inputs on a rising edge when i_valid = 1 and o_busy = 0. Otherwise its valid bit clears on that edge; there are no bubbles held over.
- Write data is computed from the registered fields:
  - ALU: alu_data.
  - pc+4: pc + 32'd4, modulo 2^32.
  - Load, byte offset = alu_data[1:0]:
    - funct3 000 LB: byte at the offset, sign-extended.
    - funct3 100 LBU: byte at the offset, zero-extended.
    - funct3 001 LH: halfword selected by alu_data[1], sign-extended; alu_data[0] is ignored.
    - funct3 101 LHU: halfword selected by alu_data[1], zero-extended.
    - funct3 010 and all other codes: full word.
- Latency:
  - Inputs sampled at edge E1 drive wren/rd_addr/rd_data combinationally during the following cycle.
  - The regfile commits at edge E2, one cycle after capture.
- Write enable outside the sweep:
  - wren = reg_valid & reg_rd_wren & (reg_rd_addr != 0).
  - x0 is never written; rd_addr and rd_data still show the registered values.
- FSM states:
  - IDLE
    - Normal writeback.
    - i_clear_req = 1 goes to SWEEP on the next edge and sets counter = 1.
    - A valid WB-register write present in that same cycle still commits.
  - SWEEP
    - wren = 1, rd_addr = counter, rd_data = 0.
    - The counter increments each cycle.
    - When counter = NREG-1, go to DONE.
    - i_clear_req is ignored in this state.
  - DONE
    - o_clear_done = 1 and wren = 0 for one cycle, then go to IDLE.
- o_busy = (state != IDLE) | i_clear_req, combinational. Nothing is captured while busy, so no instruction is lost.
- Total busy duration for one request:
  - 1 request cycle
  - NREG-1 sweep cycles
  - 1 DONE cycle
  - With NREG = 32 this is 33 cycles.
- Forwarding outputs are exact copies of the write port, including sweep writes.
- Reset mid-sweep aborts immediately: wren = 0, o_clear_done never pulses, state = IDLE.
- i_clear_req held high through DONE starts a new sweep from the IDLE that follows.

Test Plan:
- ALU op: rd = 5, wb_sel = 00, alu = 0xDEADBEEF, capture at cycle N -> cycle N+1: wren = 1, rd_addr = 5, rd_data = 0xDEADBEEF; fwd ports match.
- Loads with mem_rdata = 0x80F07F01:
  - LB, offset 2 -> 0xFFFFFFF0.
  - LBU, offset 3 -> 0x00000080.
  - LH, offset 0 -> 0x00007F01.
  - LHU, offset 2 -> 0x000080F0.
- JAL: wb_sel = 10, pc = 0xFFFFFFFC, rd = 1 -> rd_data = 0x00000000 (wraps).
- x0 target: rd = 0, rd_wren = 1, alu = 0x1234 -> wren = 0 for the whole cycle.
- Clear sweep with i_valid held 1 throughout:
  - pulse i_clear_req while an ALU write to x7 is pending -> x7 write commits first.
  - Then 31 writes of 0 to x1..x31 on consecutive cycles; o_clear_done pulses once.
  - o_busy is high for 33 cycles; the held MEM instruction is captured on the first edge after o_busy falls.
- Reset mid-sweep: assert rst_n = 0 at counter = 10 -> wren = 0 asynchronously; no o_clear_done; after release, a normal ALU write to x3 works with 1-cycle latency.
